// File: rtl/fetch_sequencer.sv
// Control FSM for the KGP-RISC core: steps each instruction through fetch,
// decode, execute and PC update, and counts retired instructions.
module fetch_sequencer #(
   parameter int FETCH_TIMEOUT = 16,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             ir_load,
   input  logic [2:0]       instr_class,
   output logic             exec_start,
   input  logic             exec_done,
   input  logic             branch_taken,
   output logic             pc_en,
   output logic [3:0]       pc_control,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] retired_cnt
);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, UPDATE, HALT, FAULT
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

   state_t     state, next_state;
   logic [7:0] wait_cnt;
   logic [2:0] class_q;
   logic       taken_q;
   logic       exec_first;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         class_q     <= '0;
         taken_q     <= 1'b0;
         exec_first  <= 1'b0;
         retired_cnt <= '0;
      end else begin
         state <= next_state;
         // Counter is held at zero outside FETCH, so every FETCH entry starts fresh.
         if (state == FETCH && !imem_ack)
            wait_cnt <= wait_cnt + 8'd1;
         else
            wait_cnt <= '0;
         if (state == DECODE)
            class_q <= instr_class;
         if (state == EXEC && exec_done)
            taken_q <= branch_taken;
         exec_first <= (state == DECODE) && (next_state == EXEC);
         if (state == UPDATE)
            retired_cnt <= retired_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      next_state = state;
      imem_req   = 1'b0;
      ir_load    = 1'b0;
      exec_start = 1'b0;
      pc_en      = 1'b0;
      pc_control = 4'b0000;
      halted     = 1'b0;
      fault      = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               next_state = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_ack;
            if (imem_ack)
               next_state = DECODE;
            else if (wait_cnt == WAIT_LAST)
               next_state = FAULT;
         end
         DECODE: begin
            case (instr_class)
               3'd0, 3'd3: next_state = EXEC;
               3'd1, 3'd2: next_state = UPDATE;
               3'd4:       next_state = HALT;
               default:    next_state = FAULT;
            endcase
         end
         EXEC: begin
            exec_start = exec_first;
            if (exec_done)
               next_state = UPDATE;
         end
         UPDATE: begin
            pc_en      = 1'b1;
            next_state = FETCH;
            case (class_q)
               3'd1:    pc_control = 4'b0001;
               3'd2:    pc_control = 4'b0010;
               3'd3:    pc_control = taken_q ? 4'b0011 : 4'b0000;
               default: pc_control = 4'b0000;
            endcase
         end
         HALT: begin
            halted = 1'b1;
            if (start)
               next_state = FETCH;
         end
         FAULT: begin
            fault = 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table plus hand-written
// sequences for reset, halt, illegal class and fetch timeout.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        imem_req;
   logic        imem_ack;
   logic        ir_load;
   logic [2:0]  instr_class;
   logic        exec_start;
   logic        exec_done;
   logic        branch_taken;
   logic        pc_en;
   logic [3:0]  pc_control;
   logic        halted;
   logic        fault;
   logic [31:0] retired_cnt;

   fetch_sequencer #(.FETCH_TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
      .instr_class(instr_class), .exec_start(exec_start),
      .exec_done(exec_done), .branch_taken(branch_taken),
      .pc_en(pc_en), .pc_control(pc_control), .halted(halted),
      .fault(fault), .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] cls;
      logic       taken;
      int         ack_wait;
      int         exec_wait;
      logic [3:0] exp_pc;
   } vec_t;

   typedef struct {
      logic [3:0] pc;
      int         cyc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   int   exec_starts = 0;
   int   saved_cnt;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Every cycle advance goes through here so the pc_en scoreboard sees each cycle.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cycle++;
      if (pc_en) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_pc_en: got pc_en=1 pc_control=%b, expected no update (cycle %0d)", pc_control, cycle);
         end else begin
            e = sb.pop_front();
            checkOutput("pc_control", int'(pc_control), int'(e.pc));
            checkOutput("pc_en_cycle", cycle, e.cyc);
         end
      end else begin
         checkOutput("pc_control_idle", int'(pc_control), 0);
      end
      if (exec_start)
         exec_starts++;
   endtask

   task automatic waitReq(output bit ok);
      int n = 0;
      while (!imem_req && n < 50) begin
         tick();
         n++;
      end
      ok = imem_req;
      if (!ok)
         checkOutput("fetch_wait", int'(imem_req), 1);
   endtask

   task automatic applyStimulus(input vec_t v);
      bit ok;
      bit jump;
      int fe;
      int starts0;
      waitReq(ok);
      if (!ok) return;
      fe   = cycle;
      jump = (v.cls == 3'd1) || (v.cls == 3'd2);
      repeat (v.ack_wait) tick();
      checkOutput("fault_before_ack", int'(fault), 0);
      sb.push_back('{v.exp_pc, fe + v.ack_wait + (jump ? 2 : 3 + v.exec_wait)});
      imem_ack    = 1'b1;
      instr_class = v.cls;
      #1;
      checkOutput("ir_load", int'(ir_load), 1);
      starts0 = exec_starts;
      tick();
      imem_ack = 1'b0;
      tick();
      if (!jump) begin
         checkOutput("exec_start_first", int'(exec_start), 1);
         repeat (v.exec_wait) tick();
         exec_done    = 1'b1;
         branch_taken = v.taken;
         tick();
         exec_done    = 1'b0;
         branch_taken = 1'b0;
      end
      checkOutput("pc_en", int'(pc_en), 1);
      checkOutput("exec_start_count", exec_starts - starts0, jump ? 0 : 1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_imem_req"}, int'(imem_req), 0);
      checkOutput({tag, "_ir_load"}, int'(ir_load), 0);
      checkOutput({tag, "_exec_start"}, int'(exec_start), 0);
      checkOutput({tag, "_pc_en"}, int'(pc_en), 0);
      checkOutput({tag, "_halted"}, int'(halted), 0);
      checkOutput({tag, "_fault"}, int'(fault), 0);
      checkOutput({tag, "_pc_control"}, int'(pc_control), 0);
      checkOutput({tag, "_retired_cnt"}, int'(retired_cnt), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit ok;
      rst = 1'b0; start = 1'b0; imem_ack = 1'b0; instr_class = 3'd0;
      exec_done = 1'b0; branch_taken = 1'b0;

      // ALU stream, control flow, then stalls including an ack on the last allowed cycle.
      vecs.push_back('{3'd0, 1'b0, 0,  0, 4'b0000});
      vecs.push_back('{3'd0, 1'b0, 0,  0, 4'b0000});
      vecs.push_back('{3'd0, 1'b0, 0,  0, 4'b0000});
      vecs.push_back('{3'd3, 1'b1, 0,  0, 4'b0011});
      vecs.push_back('{3'd3, 1'b0, 0,  0, 4'b0000});
      vecs.push_back('{3'd1, 1'b0, 0,  0, 4'b0001});
      vecs.push_back('{3'd2, 1'b0, 0,  0, 4'b0010});
      vecs.push_back('{3'd0, 1'b0, 3,  2, 4'b0000});
      vecs.push_back('{3'd3, 1'b1, 0,  3, 4'b0011});
      vecs.push_back('{3'd0, 1'b0, 15, 0, 4'b0000});

      repeat (3) tick();
      checkAllZero("por");
      rst = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("imem_req_after_start", int'(imem_req), 1);
      repeat (2) tick();
      rst = 1'b0;
      repeat (2) tick();
      checkAllZero("reset_mid_fetch");
      rst = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("imem_req_restart", int'(imem_req), 1);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         if (i == 2) begin
            tick();
            checkOutput("retired_after_alu", int'(retired_cnt), 3);
         end
      end
      tick();
      checkOutput("retired_after_table", int'(retired_cnt), vecs.size());
      checkOutput("no_fault_after_late_ack", int'(fault), 0);

      // Halt and resume
      saved_cnt = int'(retired_cnt);
      waitReq(ok);
      imem_ack = 1'b1; instr_class = 3'd4;
      tick();
      imem_ack = 1'b0;
      tick();
      checkOutput("halted", int'(halted), 1);
      repeat (3) tick();
      checkOutput("halt_retired", int'(retired_cnt), saved_cnt);
      checkOutput("halt_no_req", int'(imem_req), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("resume_halted", int'(halted), 0);
      checkOutput("resume_req", int'(imem_req), 1);
      applyStimulus('{3'd0, 1'b0, 0, 0, 4'b0000});
      tick();
      checkOutput("resume_retired", int'(retired_cnt), saved_cnt + 1);

      // Illegal class
      waitReq(ok);
      imem_ack = 1'b1; instr_class = 3'd6;
      tick();
      imem_ack = 1'b0;
      tick();
      checkOutput("illegal_fault", int'(fault), 1);
      checkOutput("illegal_req", int'(imem_req), 0);
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      checkOutput("illegal_sticky", int'(fault), 1);
      checkOutput("illegal_start_ignored", int'(imem_req), 0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checkAllZero("after_fault_reset");

      // Fetch timeout
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (15) tick();
      checkOutput("timeout_req_16", int'(imem_req), 1);
      checkOutput("timeout_fault_16", int'(fault), 0);
      tick();
      checkOutput("timeout_fault", int'(fault), 1);
      checkOutput("timeout_req_drop", int'(imem_req), 0);
      start = 1'b1;
      repeat (2) tick();
      start = 1'b0;
      checkOutput("timeout_sticky", int'(fault), 1);
      checkOutput("timeout_start_ignored", int'(imem_req), 0);
      rst = 1'b0;
      tick();
      rst = 1'b1;

      // Reset during a stalled execute
      start = 1'b1;
      tick();
      start = 1'b0;
      imem_ack = 1'b1; instr_class = 3'd0;
      tick();
      imem_ack = 1'b0;
      tick();
      checkOutput("stall_exec_start", int'(exec_start), 1);
      repeat (4) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checkAllZero("reset_mid_exec");
      repeat (3) tick();
      checkOutput("stays_idle", int'(imem_req), 0);

      checkOutput("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
